// File: rtl/path_streamer.sv
// path_streamer: replays a goal-first Dijkstra path table start-first as a valid/ready waypoint stream with headings.
module path_streamer #(
  parameter int MAX_PATH = 100,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          success,
  input  logic [31:0]   path_len,
  output logic [6:0]    rd_idx,
  input  logic [CW-1:0] rd_x,
  input  logic [CW-1:0] rd_y,
  input  logic [CW-1:0] rd_node_id,
  output logic          wp_valid,
  input  logic          wp_ready,
  output logic [CW-1:0] wp_x,
  output logic [CW-1:0] wp_y,
  output logic [CW-1:0] wp_node_id,
  output logic [1:0]    wp_heading,
  output logic          wp_last,
  output logic          busy,
  output logic          done,
  output logic          error
);
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_t;
  state_t st_q, st_d;
  logic [6:0] idx_q, idx_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d, id_q, id_d;
  logic [1:0] hd_q, hd_d, hdg;
  logic valid_q, valid_d, last_q, last_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic succ_q, first_q, first_d;
  logic signed [CW:0] dx, dy;
  logic [CW:0] ax, ay;
  assign dx = $signed({1'b0, rd_x}) - $signed({1'b0, x_q});
  assign dy = $signed({1'b0, rd_y}) - $signed({1'b0, y_q});
  assign ax = dx[CW] ? -dx : dx;
  assign ay = dy[CW] ? -dy : dy;
  // A zero-length step keeps the previous heading; ties in magnitude favour the x axis.
  assign hdg = (dx == 0 && dy == 0) ? hd_q :
               (ax >= ay) ? (dx > 0 ? 2'd1 : 2'd3) : (dy > 0 ? 2'd2 : 2'd0);
  always_comb begin
    st_d = st_q;
    idx_d = idx_q;
    x_d = x_q;
    y_d = y_q;
    id_d = id_q;
    hd_d = hd_q;
    valid_d = valid_q;
    last_d = last_q;
    busy_d = busy_q;
    first_d = first_q;
    done_d = 1'b0;
    err_d = 1'b0;
    case (st_q)
      IDLE: if (success && !succ_q) begin
        if (path_len == 0 || path_len > 32'(MAX_PATH)) err_d = 1'b1;
        else begin
          st_d = FETCH;
          idx_d = 7'(path_len - 1);
          busy_d = 1'b1;
          first_d = 1'b1;
        end
      end
      FETCH: st_d = WAIT;
      WAIT: begin
        x_d = rd_x;
        y_d = rd_y;
        id_d = rd_node_id;
        hd_d = first_q ? 2'd0 : hdg;
        last_d = idx_q == 0;
        first_d = 1'b0;
        valid_d = 1'b1;
        st_d = EMIT;
      end
      EMIT: if (wp_ready) begin
        valid_d = 1'b0;
        st_d = last_q ? DONE : FETCH;
        busy_d = !last_q;
        done_d = last_q;
        idx_d = last_q ? idx_q : idx_q - 7'd1;
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= IDLE;
      idx_q <= '0;
      x_q <= '0;
      y_q <= '0;
      id_q <= '0;
      hd_q <= '0;
      valid_q <= 1'b0;
      last_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      succ_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      st_q <= st_d;
      idx_q <= idx_d;
      x_q <= x_d;
      y_q <= y_d;
      id_q <= id_d;
      hd_q <= hd_d;
      valid_q <= valid_d;
      last_q <= last_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
      succ_q <= success;
      first_q <= first_d;
    end
  end
  assign rd_idx = idx_q;
  assign wp_valid = valid_q;
  assign wp_x = x_q;
  assign wp_y = y_q;
  assign wp_node_id = id_q;
  assign wp_heading = hd_q;
  assign wp_last = last_q;
  assign busy = busy_q;
  assign done = done_q;
  assign error = err_q;
endmodule

// File: doc/path_streamer.md
PATH_STREAMER -- requirements
Module: path_streamer

Interface
REQ-001 SHALL have parameter MAX_PATH, default 100, the maximum number of entries in the Dijkstra path table.
REQ-002 SHALL have parameter CW, default 16, the coordinate and node-id width.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port success, input, 1, Dijkstra completion flag; a level that may stay high.
REQ-006 SHALL have port path_len, input, 32, number of valid path entries (Dijkstra index i).
REQ-007 SHALL have port rd_idx, output, 7, path table read index.
REQ-008 SHALL have ports rd_x, rd_y and rd_node_id, input, CW each, entry fields valid one cycle after rd_idx.
REQ-009 SHALL have port wp_valid, output, 1, waypoint valid.
REQ-010 SHALL have port wp_ready, input, 1, downstream accept.
REQ-011 SHALL have ports wp_x, wp_y and wp_node_id, output, CW each, waypoint fields.
REQ-012 SHALL have port wp_heading, output, 2, travel direction into the waypoint: 00 N, 01 E, 10 S, 11 W.
REQ-013 SHALL have port wp_last, output, 1, high with the final waypoint.
REQ-014 SHALL have port busy, output, 1, high while streaming.
REQ-015 SHALL have ports done and error, output, 1 each, one-cycle completion pulses.

Function
REQ-016 SHALL store the path table goal-first (index 0 = goal) and emit entries from index path_len-1 down to 0, so the start node goes first.
REQ-017 SHALL start a run only on a rising edge of success (success=1, previous sample 0) while in IDLE.
REQ-018 SHALL latch path_len on that edge.
REQ-019 SHALL ignore success edges outside IDLE.
REQ-020 SHALL, if the latched length is 0 or greater than MAX_PATH, pulse error for one cycle, emit nothing and stay in IDLE.
REQ-021 SHALL implement FSM IDLE -> FETCH (drive rd_idx) -> WAIT (capture rd_* data) -> EMIT (wp_valid=1) -> FETCH for the next entry, or DONE after the last one -> IDLE.
REQ-022 SHALL assert the first wp_valid exactly 3 cycles after the cycle in which the success edge is sampled.
REQ-023 SHALL assert each later wp_valid 3 cycles after the previous handshake.
REQ-024 SHALL complete a handshake when wp_valid and wp_ready are both high on a clock edge.
REQ-025 SHALL hold all wp_* outputs stable while wp_valid=1 and wp_ready=0.
REQ-026 SHALL assert wp_valid independently of wp_ready.
REQ-027 SHALL set wp_heading to 00 (N) for the first waypoint.
REQ-028 SHALL, for every other waypoint, compute signed dx = cur.x - prev.x and dy = cur.y - prev.y, each CW+1 bits.
REQ-029 SHALL set wp_heading to E if |dx| >= |dy| and dx > 0, W if |dx| >= |dy| and dx <= 0, S if |dy| > |dx| and dy > 0, otherwise N.
REQ-030 SHALL, when dx = dy = 0, repeat the previous heading.
REQ-031 SHALL assert wp_last only with the waypoint read from index 0.
REQ-032 SHALL pulse done for one cycle in DONE, the cycle after the last handshake.
REQ-033 SHALL hold busy high from FETCH through EMIT of the last waypoint, and low in IDLE and DONE.
REQ-034 SHALL, for path_len = 1, emit a single waypoint with wp_heading = N and wp_last = 1.

Reset
REQ-035 SHALL, while reset=1 at a clock edge, enter IDLE and clear wp_valid, wp_last, busy, done, error, rd_idx, wp_heading, all wp_* fields and the success edge detector.
REQ-036 SHALL, if reset is asserted mid-run, abandon the run with no done pulse and accept a new run only on a fresh success rising edge after reset.

Verification
REQ-037 SHALL be checked with table idx0=(0x82,0x43,id 0x45), idx1=(0x50,0x30,0x17), idx2=(0x10,0x10,0x13), path_len=3 and wp_ready held 1: waypoint ids 0x13, 0x17, 0x45 in order; headings N, E, E; wp_last only on 0x45; done one cycle after the third handshake.
REQ-038 SHALL be checked with the same table and wp_ready low for 5 cycles on the second waypoint: wp_valid stays high, fields hold (0x50,0x30,0x17,E) for all 5 cycles, no duplicate or lost waypoint.
REQ-039 SHALL be checked with path_len=0, and again with path_len=101: one error pulse each, wp_valid never asserted, busy stays 0.
REQ-040 SHALL be checked with success held high through a whole run and then pulsed again mid-run: exactly one run; the mid-run pulse is ignored.
REQ-041 SHALL be checked with reset asserted while the second waypoint is pending: next cycle wp_valid=0 and busy=0, no done pulse; the next success edge restarts from id 0x13.
REQ-042 SHALL be checked with idx0=(0x10,0x40), idx1=(0x10,0x10), path_len=2: headings N then S, wp_last on the second waypoint.
